// File: rtl/fp4_dot_feeder_if.sv
// Operand-pair valid/ready channel into the FP4 dot-product feeder.
interface fp4_dot_feeder_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;

    modport master (output in_valid, output a, output b, input in_ready);
    modport slave  (input in_valid, input a, input b, output in_ready);
endinterface

// File: rtl/fp4_dot_feeder.sv
// FP4 (E2M1) operand-pair multiplier feeding a wide accumulator; sequences
// clear / accumulate / flush so every VEC_LEN accepted pairs form one dot product.
module fp4_dot_feeder #(
    parameter  int VEC_LEN = 4,
    localparam int IDX_W   = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_abort,
    fp4_dot_feeder_if.slave  in_bus,
    output logic             o_clear,
    output logic             o_acc_valid,
    output logic             o_flush,
    output logic             o_p_sign,
    output logic [2:0]       o_p_exp_u,
    output logic [4:0]       o_p_sig_grs,
    output logic [IDX_W-1:0] o_elem_idx,
    output logic [15:0]      o_vec_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic             vld_p1;
    logic [IDX_W-1:0] idx_p1;
    logic [8:0]       prod_p1;
    logic [15:0]      vec_cnt;
    logic             ready;
    logic             accept;
    logic             last;
    logic             abort_run;
    logic             flush;

    function automatic logic [8:0] sat_prod(input logic sign, input logic signed [3:0] exp_u,
                                            input logic [4:0] sig);
        if (exp_u > 4'sd3)
            return {sign, 3'b011, 5'b11000};
        return {sign, exp_u[2:0], sig};
    endfunction

    // Subnormal (e=0,m=1) decodes to 1.0 x 2^-1, so the unbiased exponent is e-1 for every nonzero code.
    function automatic logic [8:0] fp4_mul(input logic [3:0] a, input logic [3:0] b);
        logic              frac_a;
        logic              frac_b;
        logic signed [3:0] exp_sum;
        logic        [4:0] sig;
        frac_a  = a[0] && (a[2:1] != 2'b00);
        frac_b  = b[0] && (b[2:1] != 2'b00);
        exp_sum = $signed({2'b00, a[2:1]}) + $signed({2'b00, b[2:1]}) - 4'sd2;
        case ({frac_a, frac_b})
            2'b11: begin
                sig     = 5'b10010;
                exp_sum = exp_sum + 4'sd1;
            end
            2'b00:   sig = 5'b10000;
            default: sig = 5'b11000;
        endcase
        if ((a[2:0] == 3'b000) || (b[2:0] == 3'b000))
            return 9'd0;
        return sat_prod(a[3] ^ b[3], exp_sum, sig);
    endfunction

    assign last      = (idx_p1 == LAST_IDX);
    assign abort_run = i_abort && (state_q == ST_RUN);
    assign accept    = in_bus.in_valid && ready;
    assign flush     = vld_p1 && last && !i_abort;

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        o_clear = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                o_clear = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                ready = !i_abort && !(vld_p1 && last);
                if (i_abort || (vld_p1 && last))
                    state_d = ST_CLEAR;
            end
        endcase
    end

    // p0 -> p1: product register; vld_p1 drops whenever ready was low (CLEAR, abort, last element)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_CLEAR;
            vld_p1  <= 1'b0;
            idx_p1  <= '0;
            vec_cnt <= '0;
            prod_p1 <= '0;
        end else begin
            state_q <= state_d;
            vld_p1  <= accept;
            if (abort_run || (vld_p1 && last))
                idx_p1 <= '0;
            else if (vld_p1)
                idx_p1 <= idx_p1 + 1'b1;
            if (flush)
                vec_cnt <= vec_cnt + 16'd1;
            if (accept)
                prod_p1 <= fp4_mul(in_bus.a, in_bus.b);
        end
    end

    assign in_bus.in_ready = ready;
    assign o_acc_valid     = vld_p1;
    assign o_flush         = flush;
    assign o_p_sign        = prod_p1[8];
    assign o_p_exp_u       = prod_p1[7:5];
    assign o_p_sig_grs     = prod_p1[4:0];
    assign o_elem_idx      = idx_p1;
    assign o_vec_cnt       = vec_cnt;

endmodule

// File: tb/tb_fp4_dot_feeder.sv
// Directed bench for fp4_dot_feeder: hand-computed FP4 products, vector sequencing,
// abort handling and a gapped-valid stream against a queue of expected products.
module tb_fp4_dot_feeder;
    localparam int VEC_LEN = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_abort;
    logic        o_clear;
    logic        o_acc_valid;
    logic        o_flush;
    logic        o_p_sign;
    logic [2:0]  o_p_exp_u;
    logic [4:0]  o_p_sig_grs;
    logic [1:0]  o_elem_idx;
    logic [15:0] o_vec_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] ta [12];
    logic [3:0] tb [12];
    logic [8:0] te [12];

    fp4_dot_feeder_if bus ();

    fp4_dot_feeder #(.VEC_LEN(VEC_LEN)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_abort     (i_abort),
        .in_bus      (bus),
        .o_clear     (o_clear),
        .o_acc_valid (o_acc_valid),
        .o_flush     (o_flush),
        .o_p_sign    (o_p_sign),
        .o_p_exp_u   (o_p_exp_u),
        .o_p_sig_grs (o_p_sig_grs),
        .o_elem_idx  (o_elem_idx),
        .o_vec_cnt   (o_vec_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    function automatic logic [31:0] prod();
        return 32'({o_p_sign, o_p_exp_u, o_p_sig_grs});
    endfunction

    // Full-rate vector from table entries base..base+3; starts and ends in a RUN cycle.
    task automatic send_vec(input int base, input logic [15:0] vc_exp);
        chk("rdy_start", 32'(bus.in_ready), 32'(1));
        for (int k = 0; k < VEC_LEN; k++) begin
            bus.in_valid = 1'b1;
            bus.a        = ta[base + k];
            bus.b        = tb[base + k];
            step();
            chk($sformatf("prod%0d", base + k), prod(), 32'(te[base + k]));
            chk("acc_vld", 32'(o_acc_valid), 32'(1));
            chk("idx", 32'(o_elem_idx), 32'(k));
            chk("flush", 32'(o_flush), 32'(k == VEC_LEN - 1));
            chk("no_clr", 32'(o_clear), 32'(0));
            chk("rdy_mid", 32'(bus.in_ready), 32'(k != VEC_LEN - 1));
        end
        bus.in_valid = 1'b0;
        step();
        chk("clr_after", 32'(o_clear), 32'(1));
        chk("vld_in_clr", 32'(o_acc_valid), 32'(0));
        chk("rdy_in_clr", 32'(bus.in_ready), 32'(0));
        chk("vec_cnt", 32'(o_vec_cnt), 32'(vc_exp));
        step();
        chk("run_clr", 32'(o_clear), 32'(0));
        chk("run_rdy", 32'(bus.in_ready), 32'(1));
    endtask

    initial begin
        logic [8:0] q [$];
        logic [8:0] exp9;
        int         ptr;
        int         pres;

        ta[0]  = 4'b0010; tb[0]  = 4'b0010; te[0]  = 9'b0_000_10000;
        ta[1]  = 4'b0011; tb[1]  = 4'b0011; te[1]  = 9'b0_001_10010;
        ta[2]  = 4'b1010; tb[2]  = 4'b0010; te[2]  = 9'b1_000_10000;
        ta[3]  = 4'b0001; tb[3]  = 4'b0001; te[3]  = 9'b0_110_10000;
        ta[4]  = 4'b0111; tb[4]  = 4'b0111; te[4]  = 9'b0_011_11000;
        ta[5]  = 4'b1111; tb[5]  = 4'b0111; te[5]  = 9'b1_011_11000;
        ta[6]  = 4'b0000; tb[6]  = 4'b0111; te[6]  = 9'b0_000_00000;
        ta[7]  = 4'b1000; tb[7]  = 4'b1011; te[7]  = 9'b0_000_00000;
        ta[8]  = 4'b0101; tb[8]  = 4'b0100; te[8]  = 9'b0_010_11000;
        ta[9]  = 4'b1110; tb[9]  = 4'b1110; te[9]  = 9'b0_011_11000;
        ta[10] = 4'b0100; tb[10] = 4'b0001; te[10] = 9'b0_000_10000;
        ta[11] = 4'b1001; tb[11] = 4'b0011; te[11] = 9'b1_111_11000;

        i_rst_n      = 1'b0;
        i_abort      = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = 4'b0000;
        bus.b        = 4'b0000;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rst_clr", 32'(o_clear), 32'(1));
        chk("rst_rdy", 32'(bus.in_ready), 32'(0));
        chk("rst_vld", 32'(o_acc_valid), 32'(0));
        chk("rst_flush", 32'(o_flush), 32'(0));
        chk("rst_cnt", 32'(o_vec_cnt), 32'(0));
        chk("rst_idx", 32'(o_elem_idx), 32'(0));
        chk("rst_prod", prod(), 32'(0));

        i_rst_n = 1'b1;
        #1;
        chk("rel_clr", 32'(o_clear), 32'(1));
        chk("rel_rdy", 32'(bus.in_ready), 32'(0));
        step();
        chk("run0_clr", 32'(o_clear), 32'(0));
        chk("run0_rdy", 32'(bus.in_ready), 32'(1));
        chk("run0_cnt", 32'(o_vec_cnt), 32'(0));

        send_vec(0, 16'd1);
        send_vec(4, 16'd2);
        send_vec(8, 16'd3);

        // Abort while element 2 is presented
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.a        = ta[k];
            bus.b        = tb[k];
            step();
            chk("ab_prod", prod(), 32'(te[k]));
        end
        bus.a   = ta[3];
        bus.b   = tb[3];
        i_abort = 1'b1;
        #1;
        chk("ab_idx", 32'(o_elem_idx), 32'(2));
        chk("ab_vld", 32'(o_acc_valid), 32'(1));
        chk("ab_flush", 32'(o_flush), 32'(0));
        chk("ab_rdy", 32'(bus.in_ready), 32'(0));
        step();
        bus.in_valid = 1'b0;
        chk("ab_clr", 32'(o_clear), 32'(1));
        chk("ab_idx0", 32'(o_elem_idx), 32'(0));
        chk("ab_vld0", 32'(o_acc_valid), 32'(0));
        chk("ab_cnt", 32'(o_vec_cnt), 32'(3));
        step();
        chk("ab_clr_ign", 32'(o_clear), 32'(0));
        chk("ab_rdy_gate", 32'(bus.in_ready), 32'(0));
        i_abort = 1'b0;
        #1;
        chk("ab_rdy_back", 32'(bus.in_ready), 32'(1));
        send_vec(0, 16'd4);

        // Gapped valid stream over all twelve table entries
        ptr  = 0;
        pres = 0;
        for (int cyc = 0; cyc < 400 && pres < 12; cyc++) begin
            if (o_acc_valid) begin
                exp9 = (q.size() != 0) ? q.pop_front() : 9'h1ff;
                chk("gap_prod", prod(), 32'(exp9));
                chk("gap_idx", 32'(o_elem_idx), 32'(pres % VEC_LEN));
                chk("gap_flush", 32'(o_flush), 32'((pres % VEC_LEN) == VEC_LEN - 1));
                if (o_elem_idx == 2'(VEC_LEN - 1))
                    chk("gap_rdy_last", 32'(bus.in_ready), 32'(0));
                pres++;
            end
            if (o_clear)
                chk("gap_rdy_clr", 32'(bus.in_ready), 32'(0));
            if (ptr < 12) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.a        = ta[ptr];
                bus.b        = tb[ptr];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(te[ptr]);
                ptr++;
            end
            step();
        end
        bus.in_valid = 1'b0;
        chk("gap_count", 32'(pres), 32'(12));
        chk("gap_accepts", 32'(ptr), 32'(12));
        chk("gap_clr", 32'(o_clear), 32'(1));
        chk("gap_vec_cnt", 32'(o_vec_cnt), 32'(7));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp4_dot_feeder.md
# fp4_dot_feeder

Upstream stage of the FP4 MAC datapath. Accepts FP4 (E2M1, bias 1) operand pairs on a valid/ready handshake, forms the exact product in the accumulator's wide format {sign, unbiased exp, {I,F,G,R,S}}, and registers it. It sequences the accumulator's clear, accumulate and flush controls so that every VEC_LEN accepted pairs produce one packed dot-product result downstream.

## Interface
- VEC_LEN, 4: products per dot product; must be ≥1; counter width is max(1, $clog2(VEC_LEN)).
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset; asynchronous assertion, active-low.
- i_abort  in  1  synchronous abort of the current vector.
- i_in_valid  in  1  operand pair valid.
- o_in_ready  out  1  feeder can accept a pair this cycle.
- i_a, i_b  in  4 each  FP4 operands, {s, e[1:0], m}.
- o_clear  out  1  accumulator clear to +0.
- o_acc_valid  out  1  product outputs valid; accumulator consumes them.
- o_flush  out  1  accumulator packs its result, including the current product.
- o_p_sign  out  1  product sign.
- o_p_exp_u  out  3  product unbiased exponent, two's complement.
- o_p_sig_grs  out  5  product significand {I,F,G,R,S}.
- o_elem_idx  out  idx width  index of the product currently presented.
- o_vec_cnt  out  16  completed (flushed) vectors; wraps modulo 2^16.

## Operation
- FSM states:
  - CLEAR: o_clear=1, o_in_ready=0, stage empty. Always moves to RUN on the next edge.
  - RUN: o_in_ready = !i_abort && !(stage_valid && last).
- last: o_elem_idx == VEC_LEN-1.
- Operand decode:
  - e=0, m=0 → zero.
  - e=0, m=1 → sig 1.0, exp −1.
  - Otherwise → sig 1.m, exp e−1.
- Product:
  - sign = sa^sb.
  - exp = ea+eb.
  - Significand product is 1.0 → 10000, 1.5 → 11000, or 2.25. For 2.25, normalize to 1.001 with exp+1 → 10010.
- Saturation: if exp > 3, clamp to exp 3 (3'b011) and sig 11000, keeping the sign. Exp range otherwise is −2..3.
- Zero operand (including −0): product sign 0, exp 000, sig 00000. A zero product still counts as an element.
- Handshake: a pair is accepted on an edge where i_in_valid && o_in_ready. The registered product becomes stage_valid in the next cycle.
- o_acc_valid = stage_valid. o_flush = stage_valid && last.
- Index counter:
  - Increments on each edge where stage_valid is high.
  - Wraps to 0 after last.
  - The edge after a last-element cycle sets state to CLEAR and clears stage_valid.
- o_vec_cnt increments on each edge where stage_valid && last (the flush cycle).
- i_abort in RUN:
  - Next edge: stage_valid←0, index←0, state←CLEAR, o_vec_cnt unchanged.
  - The presented product is still driven with o_acc_valid that cycle. o_flush is forced 0 in that cycle.
- i_abort in CLEAR: ignored.
- Stage payload (sign/exp/sig) is held when stage_valid=0. It is ignored downstream because o_acc_valid=0.

## Timing
- Reset (i_rst_n=0): state=CLEAR, stage_valid=0, index=0, o_vec_cnt=0, payload=0.
- During reset and in the first cycle after release: o_clear=1, o_in_ready=0, o_acc_valid=0, o_flush=0.
- Latency: pair accepted at edge k → product and o_acc_valid visible in cycle k+1. For the last element, o_flush is also high in that cycle, and the accumulator's packed result is valid in cycle k+2.
- After a last-element cycle c: cycle c+1 is CLEAR (o_clear=1), and o_in_ready returns high in cycle c+2.
- Full-rate vector cost: VEC_LEN+2 cycles between first accepts of consecutive vectors.
- o_in_ready depends combinationally on i_abort and state only, never on i_in_valid.
- VEC_LEN=1: every product is last. Pattern is accept, present+flush, CLEAR, repeat.
- o_clear and o_acc_valid are never high in the same cycle.

## Test plan
- Reset release → o_clear=1 for exactly one cycle. Then o_in_ready=1, o_vec_cnt=0.
- VEC_LEN=4, pairs (0010×0010), (0011×0011), (1010×0010), (0001×0001) at full rate → products:
  - (0,000,10000)
  - (0,001,10010)
  - (1,000,10000)
  - (0,110,10000)
  - o_flush is high only with the 4th product. Next cycle o_clear=1, then o_vec_cnt=1.
- 0111×0111 → (0,011,11000), saturated. 1111×0111 → (1,011,11000).
- 0000×0111 and 1000×1011 → (0,000,00000), and each counts as an element.
- i_abort asserted while element 2 is presented → no flush. CLEAR next cycle, o_elem_idx=0, o_vec_cnt unchanged. The next vector completes normally.
- i_in_valid held high with random gaps in valid → exactly VEC_LEN accepts per vector, o_in_ready=0 in the last-element and CLEAR cycles, and no pair is lost or duplicated.
